// File: rtl/stage_seq_fsm.sv
// Multi-stage sequencer IDLE -> RUN_0..RUN_{N-1} -> IDLE, with abort, per-stage dwell timeout and sticky ERR.
// Latency 1 clk input->state; all outputs registered alongside state; no backpressure (adv/abort/clr_err are levels).
module stage_seq_fsm #(
  parameter int NUM_STAGES = 2,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8,
  localparam int SW        = $clog2(NUM_STAGES + 2)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  hold,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] adv,
  input  logic                  abort,
  input  logic                  clr_err,
  output logic [SW-1:0]         state_o,
  output logic [NUM_STAGES-1:0] stage_oh,
  output logic [NUM_STAGES-1:0] enter_p,
  output logic                  idle_hold_p,
  output logic                  done_p,
  output logic                  timeout_p,
  output logic                  err
);

  localparam logic [SW-1:0]    ST_IDLE = '0;
  localparam logic [SW-1:0]    ST_ERR  = SW'(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {K_IDLE, K_RUN, K_ERR, K_BAD} kind_t;

  logic [SW-1:0]         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_oh_q, stage_oh_d;
  logic [NUM_STAGES-1:0] enter_q, enter_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  to_q, to_d;
  logic                  err_q, err_d;

  kind_t                 kind;
  logic [NUM_STAGES-1:0] cur_oh;

  // Decode the current state into a category plus a one-hot RUN stage.
  always_comb begin
    cur_oh = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      cur_oh[k] = (state_q == SW'(k + 1));
    end
    if (state_q == ST_IDLE)  kind = K_IDLE;
    else if (|cur_oh)        kind = K_RUN;
    else if (state_q == ST_ERR) kind = K_ERR;
    else                     kind = K_BAD;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    enter_d = '0;
    hold_d  = 1'b0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    unique case (kind)
      K_IDLE: begin
        if (hold) begin
          hold_d = 1'b1;
        end else if (start) begin
          state_d    = SW'(1);
          enter_d[0] = 1'b1;
        end
      end
      K_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (|(adv & cur_oh)) begin
          if (cur_oh[NUM_STAGES-1]) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = state_q + SW'(1);
            enter_d = cur_oh << 1;
          end
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          to_d    = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      K_ERR: begin
        if (clr_err) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    stage_oh_d = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_oh_d[k] = (state_d == SW'(k + 1));
    end
    err_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stage_oh_q <= '0;
      enter_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_oh_q <= stage_oh_d;
      enter_q    <= enter_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      to_q       <= to_d;
      err_q      <= err_d;
    end
  end

  assign state_o     = state_q;
  assign stage_oh    = stage_oh_q;
  assign enter_p     = enter_q;
  assign idle_hold_p = hold_q;
  assign done_p      = done_q;
  assign timeout_p   = to_q;
  assign err         = err_q;

endmodule

// File: tb/tb_stage_seq_fsm.sv
// Directed table-driven bench for stage_seq_fsm with NUM_STAGES=2, TIMEOUT=4.
module tb_stage_seq_fsm;
  localparam int N  = 2;
  localparam int TO = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         hold = 1'b0, start = 1'b0, abort = 1'b0, clr_err = 1'b0;
  logic [N-1:0] adv = '0;
  logic [1:0]   state_o;
  logic [N-1:0] stage_oh, enter_p;
  logic         idle_hold_p, done_p, timeout_p, err;

  stage_seq_fsm #(.NUM_STAGES(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .hold(hold), .start(start), .adv(adv),
    .abort(abort), .clr_err(clr_err), .state_o(state_o), .stage_oh(stage_oh),
    .enter_p(enter_p), .idle_hold_p(idle_hold_p), .done_p(done_p),
    .timeout_p(timeout_p), .err(err)
  );

  always #5 clk = ~clk;

  // Observed bundle: {state, stage_oh, enter_p, idle_hold_p, done_p, timeout_p, err}
  wire [9:0] obs = {state_o, stage_oh, enter_p, idle_hold_p, done_p, timeout_p, err};

  typedef struct {
    logic       h, s;
    logic [1:0] a;
    logic       ab, cl;
    logic [9:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic h, s, input logic [1:0] a, input logic ab, cl,
                              input logic [1:0] st, oh, en, input logic hp, dp, tp, ep);
    vec_t v;
    v.h = h; v.s = s; v.a = a; v.ab = ab; v.cl = cl;
    v.exp = {st, oh, en, hp, dp, tp, ep};
    return v;
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (st,oh,en,hold,done,to,err)", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, s, input logic [1:0] a, input logic ab, cl);
    hold = h; start = s; adv = a; abort = ab; clr_err = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          h  s  adv    ab cl    st     oh     en     hp dp tp ep
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 2'd0, 2'b00, 2'b00, 1, 0, 0, 0)); // hold beats start
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 2'd0, 2'b00, 2'b00, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 2'd0, 2'b00, 2'b00, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 0, 0, 2'd1, 2'b01, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b10, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0)); // foreign adv ignored
    tbl.push_back(mk(0, 0, 2'b01, 0, 0, 2'd2, 2'b10, 2'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b10, 0, 0, 2'd0, 2'b00, 2'b00, 0, 1, 0, 0)); // done
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 0, 0, 2'd1, 2'b01, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 1, 0, 2'd0, 2'b00, 2'b00, 0, 0, 0, 0)); // abort beats adv
    tbl.push_back(mk(0, 1, 2'b11, 1, 1, 2'd1, 2'b01, 2'b01, 0, 0, 0, 0)); // IDLE ignores adv/abort/clr
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0)); // 4th RUN_0 cycle
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd3, 2'b00, 2'b00, 0, 0, 1, 1)); // timeout
    tbl.push_back(mk(1, 1, 2'b11, 1, 0, 2'd3, 2'b00, 2'b00, 0, 0, 0, 1)); // ERR sticky
    tbl.push_back(mk(0, 0, 2'b00, 0, 1, 2'd0, 2'b00, 2'b00, 0, 0, 0, 0)); // clr_err
    tbl.push_back(mk(0, 1, 2'b00, 0, 0, 2'd1, 2'b01, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd1, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 0, 0, 2'd2, 2'b10, 2'b10, 0, 0, 0, 0)); // adv wins over timeout
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd2, 2'b10, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd2, 2'b10, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 0, 0, 2'd2, 2'b10, 2'b00, 0, 0, 0, 0)); // counter restarted in RUN_1
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 2'd3, 2'b00, 2'b00, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 2'b00, 0, 1, 2'd0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 0, 0, 2'd1, 2'b01, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 0, 0, 2'd2, 2'b10, 2'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b10, 1, 0, 2'd0, 2'b00, 2'b00, 0, 0, 0, 0)); // abort beats final adv

    #12;
    chk("reset_state", obs, 10'b0);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].h, tbl[i].s, tbl[i].a, tbl[i].ab, tbl[i].cl);
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // Asynchronous reset from RUN_1, observed between clock edges.
    drive(0, 1, 2'b00, 0, 0);
    drive(0, 0, 2'b01, 0, 0);
    chk("run1_before_rst", obs, {2'd2, 2'b10, 2'b10, 4'b0000});
    drive(0, 0, 2'b00, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst", obs, 10'b0);
    @(posedge clk);
    #1;
    chk("rst_held", obs, 10'b0);
    rstn = 1'b1;
    drive(0, 0, 2'b00, 0, 0);
    chk("post_rst_idle", obs, 10'b0);
    drive(0, 1, 2'b00, 0, 0);
    chk("post_rst_start", obs, {2'd1, 2'b01, 2'b01, 4'b0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
